// File: rtl/stage_id_if.sv
// Fetch/writeback inputs and ID/EX outputs of the decode stage.
interface stage_id_if;
  logic [31:0] instruction_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;

  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic [31:0] imm_o;
  logic [2:0]  funct3_o;
  logic        rd_we_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic        branch_o;
  logic        jump_o;
  logic        illegal_o;

  modport master (
    output instruction_i, pc_i, valid_i,
    output stall_i, flush_i,
    output wb_we_i, wb_rd_addr_i, wb_rd_data_i,
    input  instruction_o, pc_o, valid_o,
    input  rs1_addr_o, rs2_addr_o, rd_addr_o,
    input  rs1_data_o, rs2_data_o, imm_o,
    input  funct3_o, rd_we_o, mem_re_o,
    input  mem_we_o, branch_o, jump_o,
    input  illegal_o
  );

  modport slave (
    input  instruction_i, pc_i, valid_i,
    input  stall_i, flush_i,
    input  wb_we_i, wb_rd_addr_i, wb_rd_data_i,
    output instruction_o, pc_o, valid_o,
    output rs1_addr_o, rs2_addr_o, rd_addr_o,
    output rs1_data_o, rs2_data_o, imm_o,
    output funct3_o, rd_we_o, mem_re_o,
    output mem_we_o, branch_o, jump_o,
    output illegal_o
  );
endinterface

// File: rtl/stage_id.sv
// RV32I decode stage: field decode, immediates, regfile, ID/EX register.
module stage_id #(
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input logic       clk_i,
  input logic       rst_i,
  stage_id_if.slave bus
);

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        rd_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ex_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [31:0] regs [32];
  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1, rs2, rd;

  assign ins = bus.instruction_i;
  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  logic is_load, is_misc, is_opimm, is_auipc;
  logic is_store, is_op, is_lui, is_branch;
  logic is_jalr, is_jal, is_system, known;

  assign is_load   = opc == OPC_LOAD;
  assign is_misc   = opc == OPC_MISC;
  assign is_opimm  = opc == OPC_OPIMM;
  assign is_auipc  = opc == OPC_AUIPC;
  assign is_store  = opc == OPC_STORE;
  assign is_op     = opc == OPC_OP;
  assign is_lui    = opc == OPC_LUI;
  assign is_branch = opc == OPC_BRANCH;
  assign is_jalr   = opc == OPC_JALR;
  assign is_jal    = opc == OPC_JAL;
  assign is_system = opc == OPC_SYSTEM;

  assign known = is_load | is_misc | is_opimm
               | is_auipc | is_store | is_op
               | is_lui | is_branch | is_jalr
               | is_jal | is_system;

  logic is_itype, is_utype;
  assign is_itype = is_load | is_opimm
                  | is_jalr | is_system;
  assign is_utype = is_lui | is_auipc;

  logic illegal;
  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      is_jalr:   illegal = f3 != 3'd0;
      is_branch: illegal = f3[2:1] == 2'b01;
      is_load:   illegal = (f3 == 3'd3)
                         | (f3[2:1] == 2'b11);
      is_store:  illegal = f3 > 3'd2;
      is_op:     illegal = !((f7 == 7'h00)
                   | ((f7 == 7'h20)
                   & ((f3 == 3'd0) | (f3 == 3'd5))));
      default:   illegal = !known;
    endcase
  end

  logic [31:0] imm;
  logic [19:0] sx;
  assign sx = {20{ins[31]}};

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_itype:  imm = {sx, ins[31:20]};
      is_store:  imm = {sx, ins[31:25], ins[11:7]};
      is_branch: imm = {sx[18:0], ins[31], ins[7],
                        ins[30:25], ins[11:8], 1'b0};
      is_utype:  imm = {ins[31:12], 12'h000};
      is_jal:    imm = {sx[10:0], ins[31],
                        ins[19:12], ins[20],
                        ins[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

  logic wb_hit;
  assign wb_hit = bus.wb_we_i
                & (bus.wb_rd_addr_i != 5'd0);

  // Same-cycle writeback wins over the array.
  logic [31:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = regs[rs1];
    rs2_val = regs[rs2];
    if (wb_hit && bus.wb_rd_addr_i == rs1)
      rs1_val = bus.wb_rd_data_i;
    if (wb_hit && bus.wb_rd_addr_i == rs2)
      rs2_val = bus.wb_rd_data_i;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  logic rd_we_raw;
  assign rd_we_raw = is_lui | is_auipc | is_jal
                   | is_jalr | is_load | is_opimm
                   | is_op
                   | (is_system & (f3 != 3'd0));

  id_ex_t d, q, bubble;

  always_comb begin
    bubble = '0;
    bubble.instruction = NOP_INSN;
  end

  always_comb begin
    d             = '0;
    d.instruction = ins;
    d.pc          = bus.pc_i;
    d.valid       = 1'b1;
    d.rs1_addr    = rs1;
    d.rs2_addr    = rs2;
    d.rd_addr     = rd;
    d.rs1_data    = rs1_val;
    d.rs2_data    = rs2_val;
    d.imm         = imm;
    d.funct3      = f3;
    d.illegal     = illegal;
    d.rd_we       = !illegal & rd_we_raw
                  & (rd != 5'd0);
    d.mem_re      = !illegal & is_load;
    d.mem_we      = !illegal & is_store;
    d.branch      = !illegal & is_branch;
    d.jump        = !illegal & (is_jal | is_jalr);
  end

  always_ff @(posedge clk_i) begin
    if (wb_hit)
      regs[bus.wb_rd_addr_i] <= bus.wb_rd_data_i;
  end

  // A held slot keeps tracking writebacks to its operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q <= bubble;
    end else if (bus.flush_i) begin
      q <= bubble;
    end else if (bus.stall_i) begin
      if (wb_hit && bus.wb_rd_addr_i == q.rs1_addr)
        q.rs1_data <= bus.wb_rd_data_i;
      if (wb_hit && bus.wb_rd_addr_i == q.rs2_addr)
        q.rs2_data <= bus.wb_rd_data_i;
    end else if (!bus.valid_i) begin
      q <= bubble;
    end else begin
      q <= d;
    end
  end

  assign bus.instruction_o = q.instruction;
  assign bus.pc_o          = q.pc;
  assign bus.valid_o       = q.valid;
  assign bus.rs1_addr_o    = q.rs1_addr;
  assign bus.rs2_addr_o    = q.rs2_addr;
  assign bus.rd_addr_o     = q.rd_addr;
  assign bus.rs1_data_o    = q.rs1_data;
  assign bus.rs2_data_o    = q.rs2_data;
  assign bus.imm_o         = q.imm;
  assign bus.funct3_o      = q.funct3;
  assign bus.rd_we_o       = q.rd_we;
  assign bus.mem_re_o      = q.mem_re;
  assign bus.mem_we_o      = q.mem_we;
  assign bus.branch_o      = q.branch;
  assign bus.jump_o        = q.jump;
  assign bus.illegal_o     = q.illegal;

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
Instruction Decode stage, directly downstream of the instruction fetch stage. It consumes the fetched instruction and PC, decodes RV32I fields, generates the sign-extended immediate, reads the 32x32 register file and flags illegal encodings. It also hosts the register file write port driven by writeback. Results are registered into the ID/EX pipeline register, with stall and flush support.

Parameters:
NOP_INSN, 32'h00000013, bubble instruction (addi x0,x0,0) loaded on reset and flush.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
instruction_i  in  32  instruction from fetch stage
pc_i  in  32  PC of instruction_i
valid_i  in  1  instruction_i/pc_i hold a real fetched instruction
stall_i  in  1  hold the ID/EX register
flush_i  in  1  squash, load a bubble
wb_we_i  in  1  register file write enable
wb_rd_addr_i  in  5  write address
wb_rd_data_i  in  32  write data
instruction_o  out  32  registered instruction
pc_o  out  32  registered PC
valid_o  out  1  registered slot holds a real instruction
rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register fields
rs1_data_o, rs2_data_o  out  32 each  operand values
imm_o  out  32  sign-extended immediate
funct3_o  out  3  instruction[14:12]
rd_we_o, mem_re_o, mem_we_o, branch_o, jump_o  out  1 each  control flags
illegal_o  out  1  illegal instruction detected

Behaviour:
- Reset (asynchronous, immediate on rst_i high): instruction_o=NOP_INSN; pc_o, rs*/rd addr, rs*_data, imm_o, funct3_o = 0; valid_o, all control flags, illegal_o = 0. The register file array is not reset.
- Latency: one cycle. Inputs sampled at posedge N appear on outputs after posedge N.
- Update priority per posedge:
  - flush_i=1: load a bubble. That means NOP_INSN, valid_o=0, controls=0, illegal_o=0. The PC and data fields take 0.
  - else stall_i=1: hold every output.
  - else valid_i=0: load a bubble.
  - else: load the decoded values.
- flush_i overrides stall_i.
- Register file: 32 x 32 bits. x0 reads 0 always.
  - Write at posedge when wb_we_i=1 and wb_rd_addr_i!=0.
  - Writes proceed regardless of stall_i, flush_i or valid_i.
- Read bypass: if wb_we_i=1, wb_rd_addr_i!=0 and wb_rd_addr_i equals rs1 (or rs2) of instruction_i in the same cycle, capture wb_rd_data_i instead of the array value.
- While stalled, the held rs*_data_o still refresh from a same-address writeback each cycle. This prevents stale operands across a stall.
- Immediate by opcode (instruction[6:0]), all sign-extended from bit 31:
  - I: LOAD, OP-IMM, JALR, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits 0.
  - J: JAL, bit0=0.
  - OP and MISC-MEM: imm_o=0.
- Controls:
  - rd_we: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and SYSTEM with funct3!=0. Forced 0 when rd=0.
  - mem_re: LOAD. mem_we: STORE. branch: BRANCH. jump: JAL, JALR.
- Illegal when any of:
  - opcode is outside the eleven RV32I opcodes;
  - instruction[1:0]!=2'b11;
  - JALR with funct3!=0;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3 of 3, 6 or 7;
  - STORE with funct3>2;
  - OP with funct7 not 0, or funct7=0x20 outside ADD/SRL funct3.
- On an illegal instruction: illegal_o=1, valid_o=1, all other controls 0.

Test Plan:
- Reset mid-stream: assert rst_i between edges -> outputs drop immediately to NOP_INSN/0, valid_o=0. The register file keeps its contents.
- Write x5=0xDEADBEEF, then decode 0x00528333 (add x6,x5,x5) -> rs1_data_o=rs2_data_o=0xDEADBEEF, rd_addr_o=6, rd_we_o=1.
- Same-cycle bypass: wb write x7=0x12345678 while decoding 0x00038393 (addi x7,x7,0) -> rs1_data_o=0x12345678. A write to x0 of 0xFFFFFFFF -> x0 still reads 0.
- Immediates:
  - 0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFFFFFC, branch_o=1.
  - 0x800000EF (jal) -> imm_o=0xFFF00000, jump_o=1.
  - 0xFE112E23 (sw x1,-4(x2)) -> imm_o=0xFFFFFFFC, mem_we_o=1.
- Stall and flush:
  - stall_i=1 for 3 cycles with changing inputs -> outputs constant.
  - stall_i=1 with flush_i=1 -> bubble loaded.
- Illegal encodings: 0x0000007F and 0x00003003 (ld) -> illegal_o=1, valid_o=1, rd_we_o=0.
